// File: rtl/nbcac_pkg.sv
// -----------------------------------------------------------------------------
// nbcac_pkg
// Shared definitions for the NB-CAC (Fibonacci-weighted crosstalk-avoidance)
// encoder and its matching decoder.
//   nbcac_weight(k, code_w) : weight S(k) of codeword bit k (1-based)
//   nbcac_max_val(code_w)   : largest value representable, 2*S(2)-1
//   nbcac_state_t           : encoder FSM states
//   NBCAC_WGT_W             : width used for weight values in hardware
// -----------------------------------------------------------------------------
package nbcac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        DONE = 2'd2
    } nbcac_state_t;

    localparam int NBCAC_WGT_W = 32;

    // S(1)=1, S(code_w)=S(code_w-1)=2, S(k)=S(k+1)+S(k+2) otherwise.
    // Built from the top end down, so the value is a pure constant of code_w.
    function automatic int nbcac_weight(input int k, input int code_w);
        int a;
        int b;
        int c;
        if (k == 1) begin
            return 1;
        end
        if (k >= code_w - 1) begin
            return 2;
        end
        a = 2;  // S(j+1)
        b = 2;  // S(j+2)
        for (int j = code_w - 2; j >= k; j--) begin
            c = a + b;
            b = a;
            a = c;
        end
        return a;
    endfunction

    function automatic int nbcac_max_val(input int code_w);
        return 2 * nbcac_weight(2, code_w) - 1;
    endfunction

endpackage

// File: rtl/nbcac_seq_encoder_step.sv
// -----------------------------------------------------------------------------
// nbcac_step
// Combinational single-bit decision of the greedy mixed-radix decomposition.
//   r      : current remainder
//   s_k    : weight S(k) of the bit being decided
//   s_k1   : weight S(k+1)
//   d_prev : previously decided bit d[k-1]
//   d_k    : decided bit d[k]
//   r_next : remainder after removing S(k)*d[k]
// -----------------------------------------------------------------------------
module nbcac_step #(
    parameter int R_W = 8,
    parameter int S_W = 32
) (
    input  logic [R_W-1:0] r,
    input  logic [S_W-1:0] s_k,
    input  logic [S_W-1:0] s_k1,
    input  logic           d_prev,
    output logic           d_k,
    output logic [R_W-1:0] r_next
);

    logic [S_W:0] r_x;
    logic [S_W:0] lo;
    logic [S_W:0] hi;

    always_comb begin
        r_x = (S_W + 1)'(r);
        lo  = {1'b0, s_k};
        hi  = {1'b0, s_k} + {1'b0, s_k1};
        // Ambiguous band [S(k), S(k)+S(k+1)) repeats the previous bit; this is
        // what keeps isolated 1s and 0s out of the codeword.
        if (r_x >= hi) begin
            d_k = 1'b1;
        end else if (r_x < lo) begin
            d_k = 1'b0;
        end else begin
            d_k = d_prev;
        end
        // When d_k is set, S(k) <= r, so the truncated weight fits in R_W bits.
        r_next = d_k ? (r - R_W'(s_k)) : r;
    end

endmodule

// File: rtl/nbcac_seq_encoder.sv
// -----------------------------------------------------------------------------
// nbcac_seq_encoder
// Multi-cycle NB-CAC encoder: DATA_W-bit binary word -> CODE_W-bit codeword,
// one codeword bit per clock, greedy decomposition with tie-to-previous-bit.
// Optional build macro: NBCAC_RANGE_CHK_EN adds range_err and forces a zero
// codeword for inputs above 2*S(2)-1.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake, in_data sampled only at accept
//   in_data              : binary value v
//   out_valid / out_ready: output handshake, out_code held until accepted
//   out_code             : codeword, bit 0 = d[1]
//   busy                 : encode in progress
//   range_err            : (NBCAC_RANGE_CHK_EN only) input out of range
// -----------------------------------------------------------------------------
module nbcac_seq_encoder
    import nbcac_pkg::*;
#(
    parameter int DATA_W = 7,
    parameter int CODE_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              busy
`ifdef NBCAC_RANGE_CHK_EN
    ,
    output logic              range_err
`endif
);

    localparam int R_W   = DATA_W + 1;
    localparam int KW    = $clog2(CODE_W + 2);
    localparam int WGT_W = NBCAC_WGT_W;

    if (CODE_W < 4) begin : g_code_w_chk
        $error("nbcac_seq_encoder: CODE_W must be at least 4");
    end
    if ((64'd1 << DATA_W) > (64'(nbcac_weight(2, CODE_W)) * 64'd2)) begin : g_range_chk
        $error("nbcac_seq_encoder: 2**DATA_W exceeds the codeword range 2*S(2)");
    end

`ifdef NBCAC_RANGE_CHK_EN
    localparam int unsigned MAX_VAL = int'(nbcac_max_val(CODE_W));
    logic range_err_nxt;
`endif

    nbcac_state_t      state;
    nbcac_state_t      state_nxt;
    logic [R_W-1:0]    r;
    logic [R_W-1:0]    r_nxt;
    logic [KW-1:0]     k;
    logic [KW-1:0]     k_nxt;
    logic [CODE_W-1:0] code_nxt;

    logic [WGT_W-1:0]  s_k;
    logic [WGT_W-1:0]  s_k1;
    logic              d_prev;
    logic              d_k;
    logic [R_W-1:0]    r_step;

    // k-indexed weight mux; every entry is an elaboration-time constant.
    always_comb begin
        s_k  = '0;
        s_k1 = '0;
        for (int i = 2; i <= CODE_W - 1; i++) begin
            if (k == KW'(i)) begin
                s_k  = WGT_W'(nbcac_weight(i, CODE_W));
                s_k1 = WGT_W'(nbcac_weight(i + 1, CODE_W));
            end
        end
    end

    // d[k-1] lives in out_code[k-2].
    always_comb begin
        d_prev = 1'b0;
        for (int i = 0; i < CODE_W; i++) begin
            if (k == KW'(i + 2)) begin
                d_prev = out_code[i];
            end
        end
    end

    nbcac_step #(
        .R_W (R_W),
        .S_W (WGT_W)
    ) u_step (
        .r      (r),
        .s_k    (s_k),
        .s_k1   (s_k1),
        .d_prev (d_prev),
        .d_k    (d_k),
        .r_next (r_step)
    );

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        k_nxt     = k;
        code_nxt  = out_code;
`ifdef NBCAC_RANGE_CHK_EN
        range_err_nxt = range_err;
`endif
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt   = ENC;
                    code_nxt    = '0;
                    code_nxt[0] = in_data[0];
                    r_nxt       = {1'b0, in_data} - R_W'(in_data[0]);
                    k_nxt       = KW'(2);
`ifdef NBCAC_RANGE_CHK_EN
                    range_err_nxt = (32'(in_data) > MAX_VAL);
`endif
                end
            end
            ENC: begin
                if (k < KW'(CODE_W)) begin
                    for (int i = 0; i < CODE_W; i++) begin
                        if (k == KW'(i + 1)) begin
                            code_nxt[i] = d_k;
                        end
                    end
                    r_nxt = r_step;
                    k_nxt = k + KW'(1);
                end else begin
                    // Last wire absorbs whatever remainder is left.
                    code_nxt[CODE_W-1] = (r != '0);
                    state_nxt          = DONE;
`ifdef NBCAC_RANGE_CHK_EN
                    if (range_err) begin
                        code_nxt = '0;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r         <= '0;
            k         <= '0;
            out_code  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef NBCAC_RANGE_CHK_EN
            range_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            r         <= r_nxt;
            k         <= k_nxt;
            out_code  <= code_nxt;
            out_valid <= (state_nxt == DONE);
            in_ready  <= (state_nxt == IDLE);
            busy      <= (state_nxt == ENC);
`ifdef NBCAC_RANGE_CHK_EN
            range_err <= range_err_nxt;
`endif
        end
    end

endmodule
